// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: R-type funct codes and FSM states.
package md_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1a;
   localparam logic [5:0] FN_DIVU  = 6'h1b;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } md_state_e;

   // True for any funct this unit owns.
   function automatic logic is_md_funct(input logic [5:0] f);
      return (f == FN_MFHI) || (f == FN_MTHI) || (f == FN_MFLO) || (f == FN_MTLO) ||
             (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned one-bit-per-cycle datapath: shift-add multiplier and restoring divider sharing acc/shift regs.
module muldiv_iter_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             step,
   input  logic             mul_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;

   // Remainder always stays below the divisor, so the subtraction fits in WIDTH bits.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {acc_q, sreg_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb_q});
      div_sub   = div_shift[WIDTH-1:0] - opb_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         sreg_q <= '0;
         opb_q  <= '0;
      end else if (load) begin
         acc_q  <= '0;
         sreg_q <= a;
         opb_q  <= b;
      end else if (step) begin
         if (mul_mode) begin
            acc_q  <= mul_sum[WIDTH:1];
            sreg_q <= {mul_sum[0], sreg_q[WIDTH-1:1]};
         end else if (div_ge) begin
            acc_q  <= div_sub;
            sreg_q <= {sreg_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_q  <= div_shift[WIDTH-1:0];
            sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign hi = acc_q;
   assign lo = sreg_q;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage HI/LO multiply-divide unit: decode, sequencing FSM, sign fix-up, HI/LO ownership and stall.
module muldiv_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             issue_valid,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             issue_ready,
   output logic             stall,
   output logic [WIDTH-1:0] mf_data,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             done,
   output logic             div_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned PW    = 2 * WIDTH;

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             neg_p_q, neg_p_d, neg_r_q, neg_r_d;
   logic             dz_q, dz_d, is_mul_q, is_mul_d;
   logic             done_q, done_d, dzp_q, dzp_d;

   logic             md_valid, accept, is_signed, is_div, a_neg, b_neg, rt_zero;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             core_load, core_step;
   logic [WIDTH-1:0] core_a, core_hi, core_lo;
   logic [PW-1:0]    prod_u, prod_s;
   logic [WIDTH-1:0] quo_s, rem_s;

   assign md_valid    = issue_valid && (opcode == OP_RTYPE) && is_md_funct(funct);
   assign issue_ready = (state_q == IDLE);
   assign accept      = md_valid && issue_ready && !flush;
   assign stall       = md_valid && !accept;

   // Operand magnitudes; signed ops iterate on these and fix signs at the end.
   assign is_signed = (funct == FN_MULT) || (funct == FN_DIV);
   assign is_div    = (funct == FN_DIV) || (funct == FN_DIVU);
   assign a_neg     = is_signed && rs_val[WIDTH-1];
   assign b_neg     = is_signed && rt_val[WIDTH-1];
   assign a_mag     = a_neg ? -rs_val : rs_val;
   assign b_mag     = b_neg ? -rt_val : rt_val;
   assign rt_zero   = (rt_val == '0);

   assign prod_u = {core_hi, core_lo};
   assign prod_s = neg_p_q ? -prod_u : prod_u;
   assign quo_s  = neg_p_q ? -core_lo : core_lo;
   assign rem_s  = neg_r_q ? -core_hi : core_hi;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_p_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         is_mul_q <= 1'b0;
         done_q   <= 1'b0;
         dzp_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         neg_p_q  <= neg_p_d;
         neg_r_q  <= neg_r_d;
         dz_q     <= dz_d;
         is_mul_q <= is_mul_d;
         done_q   <= done_d;
         dzp_q    <= dzp_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_p_d   = neg_p_q;
      neg_r_d   = neg_r_q;
      dz_d      = dz_q;
      is_mul_d  = is_mul_q;
      done_d    = 1'b0;
      dzp_d     = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      core_a    = a_mag;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (funct == FN_MTHI) begin
                  hi_d = rs_val;
               end else if (funct == FN_MTLO) begin
                  lo_d = rs_val;
               end else if (funct == FN_MULT || funct == FN_MULTU) begin
                  state_d   = MUL;
                  cnt_d     = CNT_W'(WIDTH);
                  core_load = 1'b1;
                  is_mul_d  = 1'b1;
                  dz_d      = 1'b0;
                  neg_p_d   = a_neg ^ b_neg;
                  neg_r_d   = 1'b0;
               end else if (is_div) begin
                  core_load = 1'b1;
                  is_mul_d  = 1'b0;
                  dz_d      = rt_zero;
                  if (rt_zero) begin
                     // Raw dividend parks in the shift register so FIX can return it as HI.
                     state_d = FIX;
                     core_a  = rs_val;
                     neg_p_d = 1'b0;
                     neg_r_d = 1'b0;
                  end else begin
                     state_d = DIV;
                     cnt_d   = CNT_W'(WIDTH);
                     neg_p_d = a_neg ^ b_neg;
                     neg_r_d = a_neg;
                  end
               end
            end
         end
         MUL, DIV: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               core_step = 1'b1;
               cnt_d     = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               done_d = 1'b1;
               dzp_d  = dz_q;
               if (dz_q) begin
                  hi_d = core_lo;
                  lo_d = '1;
               end else if (is_mul_q) begin
                  {hi_d, lo_d} = prod_s;
               end else begin
                  hi_d = rem_s;
                  lo_d = quo_s;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (core_load),
      .step     (core_step),
      .mul_mode (is_mul_q),
      .a        (core_a),
      .b        (b_mag),
      .hi       (core_hi),
      .lo       (core_lo)
   );

   assign mf_data  = (funct == FN_MFHI) ? hi_q : lo_q;
   assign hi_o     = hi_q;
   assign lo_o     = lo_q;
   assign done     = done_q;
   assign div_zero = dzp_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        issue_valid;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        issue_ready;
   logic        stall;
   logic [31:0] mf_data;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        done;
   logic        div_zero;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
   localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .issue_valid (issue_valid),
      .opcode      (opcode),
      .funct       (funct),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .flush       (flush),
      .issue_ready (issue_ready),
      .stall       (stall),
      .mf_data     (mf_data),
      .hi_o        (hi_o),
      .lo_o        (lo_o),
      .done        (done),
      .div_zero    (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat, input logic edz);
      int lat;
      issue_valid = 1'b1;
      opcode      = 6'h00;
      funct       = fn;
      rs_val      = a;
      rt_val      = b;
      tick();
      issue_valid = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(elat));
      check({tag, "_hi"}, 64'(hi_o), 64'(ehi));
      check({tag, "_lo"}, 64'(lo_o), 64'(elo));
      check({tag, "_divzero"}, 64'(div_zero), 64'(edz));
      tick();
      check({tag, "_done_pulse"}, 64'(done), 64'(0));
      check({tag, "_ready_after"}, 64'(issue_ready), 64'(1));
   endtask

   initial begin
      int n;
      int pulses;
      reset_n     = 1'b0;
      issue_valid = 1'b0;
      opcode      = 6'h00;
      funct       = 6'h00;
      rs_val      = '0;
      rt_val      = '0;
      flush       = 1'b0;
      tick();
      tick();
      check("rst_hi", 64'(hi_o), 64'(0));
      check("rst_lo", 64'(lo_o), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_divzero", 64'(div_zero), 64'(0));
      check("rst_ready", 64'(issue_ready), 64'(1));
      check("rst_stall", 64'(stall), 64'(0));
      reset_n = 1'b1;
      tick();

      run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0);
      check("mult_stall_after", 64'(stall), 64'(0));
      run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
      run_op("mult_maxpos", F_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 33, 1'b0);
      run_op("div_neg7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
      run_op("div_7_neg2", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0);
      run_op("div_minint", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0);
      run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
      run_op("divu_by0", F_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, 1'b1);

      // MULT immediately followed by MFLO: MFLO stalls for the whole busy window.
      issue_valid = 1'b1;
      funct       = F_MULT;
      rs_val      = 32'd6;
      rt_val      = 32'd7;
      tick();
      funct = F_MFLO;
      n = 0;
      while (stall && n < 100) begin
         n++;
         tick();
      end
      check("mflo_stall_cycles", 64'(n), 64'(33));
      check("mflo_data", 64'(mf_data), 64'(42));
      check("mflo_ready", 64'(issue_ready), 64'(1));
      issue_valid = 1'b0;
      tick();

      // MTHI / MTLO then MFHI readback.
      issue_valid = 1'b1;
      funct       = F_MTHI;
      rs_val      = 32'd5;
      tick();
      check("mthi_hi", 64'(hi_o), 64'(5));
      check("mthi_no_done", 64'(done), 64'(0));
      funct  = F_MTLO;
      rs_val = 32'd9;
      tick();
      check("mtlo_lo", 64'(lo_o), 64'(9));
      funct = F_MFHI;
      #1;
      check("mfhi_data", 64'(mf_data), 64'(5));
      issue_valid = 1'b0;
      tick();

      // Flush on the same cycle as issue squashes the issue.
      issue_valid = 1'b1;
      funct       = F_MULT;
      rs_val      = 32'd3;
      rt_val      = 32'd3;
      flush       = 1'b1;
      tick();
      issue_valid = 1'b0;
      flush       = 1'b0;
      check("flush_issue_ready", 64'(issue_ready), 64'(1));

      // Flush ten cycles into a DIV: back to IDLE, HI/LO untouched, no done ever.
      issue_valid = 1'b1;
      funct       = F_DIVU;
      rs_val      = 32'd100;
      rt_val      = 32'd7;
      tick();
      issue_valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_ready", 64'(issue_ready), 64'(1));
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) pulses++;
         tick();
      end
      check("flush_no_done", 64'(pulses), 64'(0));
      check("flush_hi", 64'(hi_o), 64'(5));
      check("flush_lo", 64'(lo_o), 64'(9));

      // Reset mid-MULT: HI/LO cleared, IDLE, no done afterwards.
      issue_valid = 1'b1;
      funct       = F_MULT;
      rs_val      = 32'd11;
      rt_val      = 32'd13;
      tick();
      issue_valid = 1'b0;
      check("mid_mult_busy", 64'(issue_ready), 64'(0));
      repeat (5) tick();
      reset_n = 1'b0;
      #1;
      check("rst_mid_hi", 64'(hi_o), 64'(0));
      check("rst_mid_lo", 64'(lo_o), 64'(0));
      check("rst_mid_ready", 64'(issue_ready), 64'(1));
      tick();
      reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) pulses++;
         tick();
      end
      check("rst_mid_no_done", 64'(pulses), 64'(0));
      check("rst_mid_lo_after", 64'(lo_o), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
